// File: rtl/mul_sched_pkg.sv
// Shared types and helpers for the round-robin multiplier scheduler.
package mul_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic int cnt_width(input int timeout_cyc);
    return (timeout_cyc > 1) ? $clog2(timeout_cyc) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first active request at or after ptr wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               valid
);

  assign valid = |req;

  // Walk from the farthest position back toward ptr so the closest hit is kept.
  always_comb begin
    int pos;
    logic [ID_W-1:0] pos_idx;
    grant_idx = '0;
    pos       = 0;
    pos_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pos_idx = ID_W'(pos);
      if (req[pos_idx]) grant_idx = pos_idx;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant
      assign grant[gi] = valid && (grant_idx == ID_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/mul_rr_scheduler.sv
// Shares one sequential multiplier among NUM_REQ requesters with round-robin
// arbitration, a registered req/ack handshake and a completion watchdog.
module mul_rr_scheduler
  import mul_sched_pkg::*;
#(
  parameter int OP_WIDTH    = 8,
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*2*OP_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [2*OP_WIDTH-1:0]         ack_data,
  output logic                          ack_err,
  output logic                          mul_start,
  output logic [OP_WIDTH-1:0]           mul_op1,
  output logic [OP_WIDTH-1:0]           mul_op2,
  input  logic [2*OP_WIDTH-1:0]         mul_result,
  input  logic                          mul_done,
  output logic                          busy,
  output logic [ID_W-1:0]               grant_id
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYC);
  localparam int PW    = 2 * OP_WIDTH;

  state_t           state_reg;
  logic [ID_W-1:0]  ptr_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [PW-1:0]      req_slice [NUM_REQ];
  logic [PW-1:0]      sel_data;
  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign req_slice[gi] = req_data[gi*PW +: PW];
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req),
    .ptr       (ptr_reg),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  // One-hot AND-OR mux of the winning requester's operand slice.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (arb_grant[k]) sel_data = sel_data | req_slice[k];
    end
  end

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      grant_id  <= '0;
      mul_op1   <= '0;
      mul_op2   <= '0;
      mul_start <= 1'b0;
      ack       <= '0;
      ack_data  <= '0;
      ack_err   <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      ack       <= '0;
      case (state_reg)
        IDLE: begin
          if (arb_valid) begin
            grant_id  <= arb_idx;
            mul_op1   <= sel_data[PW-1:OP_WIDTH];
            mul_op2   <= sel_data[OP_WIDTH-1:0];
            ptr_reg   <= (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            mul_start <= 1'b1;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_reg   <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          // A done pulse on the terminal count still counts as a good result.
          if (mul_done) begin
            ack       <= NUM_REQ'(1) << grant_id;
            ack_data  <= mul_result;
            ack_err   <= 1'b0;
            state_reg <= RESP;
          end else if (cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
            ack       <= NUM_REQ'(1) << grant_id;
            ack_data  <= '0;
            ack_err   <= 1'b1;
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RESP: begin
          ack_data  <= '0;
          ack_err   <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Self-checking bench: behavioural multiplier plus an expected-ack scoreboard.
module tb_mul_rr_scheduler;

  localparam int OPW = 8;
  localparam int NR  = 4;
  localparam int TO  = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req;
  logic [NR*16-1:0] req_data;
  logic [NR-1:0]    ack;
  logic [15:0]      ack_data;
  logic             ack_err;
  logic             mul_start;
  logic [7:0]       mul_op1;
  logic [7:0]       mul_op2;
  logic [15:0]      mul_result;
  logic             mul_done;
  logic             busy;
  logic [1:0]       grant_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [15:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  bit   withhold = 1'b0;
  bit   inject   = 1'b0;
  int   mul_lat  = 5;
  logic [7:0] m_a, m_b;
  int   m_cnt;
  bit   m_busy;

  always #5 clk = ~clk;

  mul_rr_scheduler #(
    .OP_WIDTH    (OPW),
    .NUM_REQ     (NR),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .ack_data   (ack_data),
    .ack_err    (ack_err),
    .mul_start  (mul_start),
    .mul_op1    (mul_op1),
    .mul_op2    (mul_op2),
    .mul_result (mul_result),
    .mul_done   (mul_done),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  // Behavioural multiplier: product mul_lat cycles after start, unless withheld.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy     <= 1'b0;
      m_cnt      <= 0;
      m_a        <= '0;
      m_b        <= '0;
      mul_done   <= 1'b0;
      mul_result <= '0;
    end else begin
      mul_done <= 1'b0;
      if (inject) begin
        mul_done   <= 1'b1;
        mul_result <= 16'h1234;
      end else if (mul_start) begin
        m_busy <= 1'b1;
        m_cnt  <= mul_lat;
        m_a    <= mul_op1;
        m_b    <= mul_op2;
      end else if (m_busy) begin
        if (m_cnt <= 1) begin
          m_busy <= 1'b0;
          if (!withhold) begin
            mul_done   <= 1'b1;
            mul_result <= 16'(m_a) * 16'(m_b);
          end
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (|ack) $display("txn ack=%b grant_id=%0d data=%h err=%b", ack, grant_id, ack_data, ack_err);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  function automatic exp_t mk(input int id, input logic [15:0] d, input logic err);
    exp_t e;
    e.id   = id;
    e.data = d;
    e.err  = err;
    return e;
  endfunction

  function automatic logic [NR-1:0] onehot(input int id);
    logic [NR-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    req_data[i*16 +: 16] = {a, b};
  endtask

  task automatic wait_ack(input int limit, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < limit && !seen; c++) begin
      tick();
      if (|ack) seen = 1'b1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req      = '0;
    req_data = '0;
    rst_n    = 1'b0;
    tick();
    tick();
    checks++;
    if ({ack, ack_data, ack_err, mul_start, mul_op1, mul_op2, busy, grant_id} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b data=%h err=%b start=%b op1=%h op2=%h busy=%b gid=%0d, want all 0",
               ack, ack_data, ack_err, mul_start, mul_op1, mul_op2, busy, grant_id);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || mul_start !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b start=%b, want 0 0", busy, mul_start);
    end
  endtask

  task automatic test_single();
    int   n;
    exp_t e;
    set_ops(2, 8'd5, 8'd7);
    sb.push_back(mk(2, 16'h0023, 1'b0));
    req = 4'b0100;
    n = 1;
    while (mul_start !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL single_start_latency: got %0d cycles, want 2", n);
    end
    checks++;
    if ({grant_id, mul_op1, mul_op2} !== {2'd2, 8'd5, 8'd7}) begin
      errors++;
      $display("FAIL single_issue_ops: gid=%0d op1=%h op2=%h, want 2 05 07", grant_id, mul_op1, mul_op2);
    end
    n = 0;
    while (mul_done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if (ack !== 4'b0100) begin
      errors++;
      $display("FAIL single_done_to_ack: ack=%b one cycle after done, want 0100", ack);
    end
    e = sb.pop_front();
    checks++;
    if ({ack, ack_data, ack_err} !== {onehot(e.id), e.data, e.err}) begin
      errors++;
      $display("FAIL single_result: ack=%b data=%h err=%b, want ack=%b data=%h err=%b",
               ack, ack_data, ack_err, onehot(e.id), e.data, e.err);
    end
    req = '0;
    tick();
    tick();
    checks++;
    if ({ack, busy} !== '0) begin
      errors++;
      $display("FAIL single_quiet_after: ack=%b busy=%b, want 0 0", ack, busy);
    end
  endtask

  task automatic test_fairness();
    bit   seen;
    int   extra;
    int   order [5] = '{0, 1, 2, 3, 0};
    exp_t e;
    apply_reset();
    for (int i = 0; i < NR; i++) set_ops(i, 8'(i + 2), 8'(i + 3));
    for (int t = 0; t < 5; t++)
      sb.push_back(mk(order[t], 16'(order[t] + 2) * 16'(order[t] + 3), 1'b0));
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_ack(100, seen);
      e = sb.pop_front();
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL fair_ack_timeout[%0d]: no ack within 100 cycles, want ack for id %0d", t, e.id);
      end else begin
        checks++;
        if ({ack, grant_id, ack_data, ack_err} !== {onehot(e.id), 2'(e.id), e.data, e.err}) begin
          errors++;
          $display("FAIL fair_order[%0d]: ack=%b gid=%0d data=%h err=%b, want ack=%b gid=%0d data=%h err=0",
                   t, ack, grant_id, ack_data, ack_err, onehot(e.id), e.id, e.data);
        end
        checks++;
        if (!$onehot(ack)) begin
          errors++;
          $display("FAIL fair_onehot[%0d]: ack=%b, want exactly one bit", t, ack);
        end
      end
      if (t == 4) req = '0;
    end
    extra = 0;
    repeat (8) begin
      tick();
      if (|ack) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL fair_no_extra: %0d extra acks, want 0", extra);
    end
  endtask

  task automatic test_boundary();
    bit   seen;
    exp_t e;
    set_ops(1, 8'hFF, 8'hFF);
    set_ops(3, 8'h00, 8'hA5);
    sb.push_back(mk(1, 16'hFE01, 1'b0));
    sb.push_back(mk(3, 16'h0000, 1'b0));
    for (int t = 0; t < 2; t++) begin
      req = (t == 0) ? 4'b0010 : 4'b1000;
      wait_ack(100, seen);
      e = sb.pop_front();
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL boundary_ack_timeout[%0d]: no ack, want ack for id %0d", t, e.id);
      end else begin
        checks++;
        if ({ack, ack_data, ack_err} !== {onehot(e.id), e.data, e.err}) begin
          errors++;
          $display("FAIL boundary_result[%0d]: ack=%b data=%h err=%b, want ack=%b data=%h err=0",
                   t, ack, ack_data, ack_err, onehot(e.id), e.data);
        end
      end
      req = '0;
      tick();
    end
  endtask

  task automatic test_timeout();
    int   n;
    int   extra;
    exp_t e;
    withhold = 1'b1;
    set_ops(0, 8'd3, 8'd4);
    sb.push_back(mk(0, 16'h0000, 1'b1));
    req = 4'b0001;
    n = 0;
    while (mul_start !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    n = 0;
    while (ack === '0 && n < TO + 10) begin
      tick();
      n++;
    end
    req = '0;
    checks++;
    if (n !== TO + 1) begin
      errors++;
      $display("FAIL timeout_latency: ack %0d cycles after start, want %0d", n, TO + 1);
    end
    e = sb.pop_front();
    checks++;
    if ({ack, ack_data, ack_err} !== {onehot(e.id), e.data, e.err}) begin
      errors++;
      $display("FAIL timeout_result: ack=%b data=%h err=%b, want ack=%b data=0000 err=1",
               ack, ack_data, ack_err, onehot(e.id));
    end
    withhold = 1'b0;
    tick();
    inject = 1'b1;
    tick();
    inject = 1'b0;
    extra = 0;
    repeat (8) begin
      tick();
      if (|ack) extra++;
    end
    checks++;
    if (extra !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL late_done_ignored: extra acks=%0d busy=%b, want 0 0", extra, busy);
    end
  endtask

  task automatic test_reset_mid();
    int   n;
    bit   seen;
    exp_t e;
    set_ops(1, 8'd9, 8'd9);
    req = 4'b0010;
    n = 0;
    while (mul_start !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_busy: busy=%b before reset, want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ack, ack_data, ack_err, mul_start, mul_op1, mul_op2, busy, grant_id} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: ack=%b data=%h err=%b start=%b op1=%h op2=%h busy=%b gid=%0d, want all 0",
               ack, ack_data, ack_err, mul_start, mul_op1, mul_op2, busy, grant_id);
    end
    tick();
    tick();
    rst_n = 1'b1;
    sb.push_back(mk(1, 16'h0051, 1'b0));
    wait_ack(100, seen);
    e = sb.pop_front();
    checks++;
    if (!seen || {ack, ack_data, ack_err} !== {onehot(e.id), e.data, e.err}) begin
      errors++;
      $display("FAIL reset_mid_rerequest: seen=%b ack=%b data=%h err=%b, want ack=%b data=%h err=0",
               seen, ack, ack_data, ack_err, onehot(e.id), e.data);
    end
    req = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    int   n;
    bit   seen;
    exp_t e;
    set_ops(1, 8'h10, 8'h10);
    set_ops(0, 8'd6, 8'd7);
    sb.push_back(mk(1, 16'h0100, 1'b0));
    sb.push_back(mk(0, 16'h002A, 1'b0));
    sb.push_back(mk(1, 16'h0100, 1'b0));
    req = 4'b0010;
    for (int t = 0; t < 3; t++) begin
      wait_ack(100, seen);
      e = sb.pop_front();
      checks++;
      if (!seen || {ack, ack_data, ack_err} !== {onehot(e.id), e.data, e.err}) begin
        errors++;
        $display("FAIL b2b_result[%0d]: seen=%b ack=%b data=%h err=%b, want ack=%b data=%h err=0",
                 t, seen, ack, ack_data, ack_err, onehot(e.id), e.data);
      end
      if (t == 0) begin
        req = 4'b0011;
        n = 0;
        while (mul_start !== 1'b1 && n < 10) begin
          tick();
          n++;
        end
        checks++;
        if (n !== 2) begin
          errors++;
          $display("FAIL b2b_ack_to_start: %0d cycles, want 2", n);
        end
      end else if (t == 1) begin
        req = 4'b0010;
      end else begin
        req = '0;
      end
    end
  endtask

  initial begin
    req      = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_fairness();
    test_boundary();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
